conv_out_packer: RTL

- Downstream stage of the convolution controller/MAC datapath.
- Accepts one accumulated MAC result per completed output pixel.
- Requantizes each result to an 8-bit unsigned pixel and packs PACK pixels into one memory word.
- Writes packed words to output memory at consecutive addresses through a req/ack write port, with a 2-entry word queue so that MAC output is not stalled by short memory waits.

---
 rtl/conv_out_packer_if.sv | 26 ++
 rtl/conv_out_packer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/conv_out_packer_if.sv
// Result stream and packed-word memory write port of the convolution output packer.
// The master side is the packer; the slave side is the MAC datapath plus memory.
interface conv_out_packer_if #(
  parameter int ACC_W  = 32,
  parameter int PIX_W  = 8,
  parameter int PACK   = 4,
  parameter int ADDR_W = 16
);
  logic                    res_valid;
  logic [ACC_W-1:0]        res_data;
  logic                    res_ready;
  logic                    mem_wr_req;
  logic [ADDR_W-1:0]       mem_wr_addr;
  logic [PACK*PIX_W-1:0]   mem_wr_data;
  logic                    mem_wr_ack;

  modport master (
    input  res_valid, res_data, mem_wr_ack,
    output res_ready, mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output res_valid, res_data, mem_wr_ack,
    input  res_ready, mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/conv_out_packer.sv
// Requantizes signed MAC results to unsigned pixels, packs PACK pixels per word and
// writes the words to consecutive addresses through a 2-entry queue.
module conv_out_packer #(
  parameter int ACC_W  = 32,
  parameter int PIX_W  = 8,
  parameter int PACK   = 4,
  parameter int SHIFT  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                flush,
  conv_out_packer_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   words_written
);
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                        state, state_next;
  logic [PACK-1:0][PIX_W-1:0]    partial, packed_word;
  logic [LANE_W-1:0]             lane;
  logic [ADDR_W-1:0]             next_addr;
  logic [ADDR_W-1:0]             q_addr [2];
  logic [PACK*PIX_W-1:0]         q_data [2];
  logic                          rd_ptr, wr_ptr;
  logic [1:0]                    count;
  logic signed [ACC_W-1:0]       shifted;
  logic [PIX_W-1:0]              pix;
  logic                          accept, push, pop, q_full, q_empty;
  logic [PACK*PIX_W-1:0]         push_data;

  assign q_full          = (count == 2'd2);
  assign q_empty         = (count == 2'd0);
  assign bus.res_ready   = (state == RUN) && !q_full;
  assign accept          = bus.res_valid && bus.res_ready;
  assign pop             = !q_empty && bus.mem_wr_ack;
  assign bus.mem_wr_req  = !q_empty;
  assign bus.mem_wr_addr = q_addr[rd_ptr];
  assign bus.mem_wr_data = q_data[rd_ptr];
  assign busy            = (state != IDLE);

  always_comb begin
    shifted = $signed(bus.res_data) >>> SHIFT;
    if (shifted < 0)
      pix = '0;
    else if (shifted > PIX_MAX)
      pix = '1;
    else
      pix = shifted[PIX_W-1:0];
  end

  // A word is pushed either when its last lane fills, or in FLUSH as a zero-padded partial.
  always_comb begin
    packed_word       = partial;
    packed_word[lane] = pix;
    push              = 1'b0;
    push_data         = packed_word;
    if (accept && lane == LAST_LANE) begin
      push = 1'b1;
    end else if (state == FLUSH && lane != '0 && !q_full) begin
      push      = 1'b1;
      push_data = partial;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (flush) state_next = FLUSH;
      FLUSH: begin
        if (lane == '0 && q_empty) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane          <= '0;
      partial       <= '0;
      next_addr     <= '0;
      words_written <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else if (state == IDLE && start) begin
      next_addr     <= base_addr;
      lane          <= '0;
      partial       <= '0;
      words_written <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      if (accept) begin
        if (lane == LAST_LANE) begin
          lane    <= '0;
          partial <= '0;
        end else begin
          lane    <= lane + LANE_W'(1);
          partial <= packed_word;
        end
      end else if (state == FLUSH && push) begin
        lane    <= '0;
        partial <= '0;
      end
      if (push) begin
        q_addr[wr_ptr] <= next_addr;
        q_data[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
        next_addr      <= next_addr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr        <= ~rd_ptr;
        words_written <= words_written + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule
